// File: rtl/dmem_wait_responder_pkg.sv
// Shared types and widths for the wait-state data-memory responder.
package dmem_wait_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int BE_W   = 4;
  localparam int WOFF_W = 2;

endpackage

// File: rtl/dmem_wait_responder_byte_merge.sv
// Combinational byte-lane merge of store data into the existing word.
module dmem_wait_responder_byte_merge
  import dmem_wait_responder_pkg::*;
(
  input  logic [31:0]     old_i,
  input  logic [31:0]     wdata_i,
  input  logic [BE_W-1:0] be_i,
  output logic [31:0]     merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < BE_W; i++) begin
      if (be_i[i]) merged_o[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// Handshaked data-memory target: one access at a time, WAIT_CYCLES wait states,
// single-cycle ready pulse, error flag for misaligned or out-of-range addresses.
module dmem_wait_responder
  import dmem_wait_responder_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [BE_W-1:0] be,
  output logic            ready,
  output logic [31:0]     rdata,
  output logic            err
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [31:0]       mem [DEPTH];

  logic [31:0]       off;
  logic              in_err;
  logic [IDX_W-1:0]  in_idx;
  logic              capture;
  logic              sel_we;
  logic              sel_err;
  logic [IDX_W-1:0]  sel_idx;
  logic [31:0]       merged;

  // Offset subtraction wraps below BASE_ADDR, so such addresses land out of range too.
  assign off     = addr - BASE_ADDR;
  assign in_err  = (addr[WOFF_W-1:0] != '0) || (off >= SPAN);
  assign in_idx  = off[IDX_W+WOFF_W-1:WOFF_W];
  assign capture = (state_q == ST_IDLE) && req;

  // With zero wait states RESP follows IDLE directly, so the read uses live inputs.
  assign sel_we  = (state_q == ST_IDLE) ? we     : we_q;
  assign sel_err = (state_q == ST_IDLE) ? in_err : err_q;
  assign sel_idx = (state_q == ST_IDLE) ? in_idx : idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_RESP && !sel_we && !sel_err) rdata_d = mem[sel_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (capture) err_q <= in_err;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      we_q    <= we;
      idx_q   <= in_idx;
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  dmem_wait_responder_byte_merge u_merge (
    .old_i    (mem[idx_q]),
    .wdata_i  (wdata_q),
    .be_i     (be_q),
    .merged_o (merged)
  );

  // Store commits on the edge leaving RESP; a reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_RESP && we_q && !err_q) mem[idx_q] <= merged;
  end

  assign ready = (state_q == ST_RESP);
  assign err   = ready & err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench: instance A (WAIT_CYCLES=2, base 0) and instance B (no wait states, base 0x1000).
module tb_dmem_wait_responder;

  localparam int          DEPTH_A = 64;
  localparam int          WC_A    = 2;
  localparam logic [31:0] BASE_A  = 32'h0000_0000;
  localparam int          DEPTH_B = 16;
  localparam int          WC_B    = 0;
  localparam logic [31:0] BASE_B  = 32'h0000_1000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model_a [DEPTH_A];
  logic [31:0] model_b [DEPTH_B];
  logic        prev_rdy [2];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_wait_responder #(.DEPTH(DEPTH_A), .WAIT_CYCLES(WC_A), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0])
  );

  dmem_wait_responder #(.DEPTH(DEPTH_B), .WAIT_CYCLES(WC_B), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1])
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every falling edge, pop and compare on ready, otherwise outputs must be quiet.
  task automatic mon(int d);
    string tag = (d == 0) ? "A" : "B";
    exp_t  e;
    if (ready[d] === 1'b1) begin
      chk({tag, ".no_consecutive_ready"}, 32'(prev_rdy[d]), 32'd0);
      if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
        compared++;
        mismatched++;
        $display("FAIL %s.unexpected_ready: got ready=1, expected no response (cycle %0d)", tag, cyc);
      end else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        chk({tag, ".rdata"}, rdata[d], e.rdata);
        chk({tag, ".err"}, 32'(err[d]), 32'(e.err));
        chk({tag, ".latency"}, 32'(cyc), 32'(e.due));
      end
    end else begin
      chk({tag, ".idle_ready"}, 32'(ready[d]), 32'd0);
      chk({tag, ".idle_rdata"}, rdata[d], 32'd0);
      chk({tag, ".idle_err"}, 32'(err[d]), 32'd0);
    end
    prev_rdy[d] = ready[d];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Present a request in the current (IDLE) cycle and predict its response.
  task automatic issue(int d, logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] b,
                       bit push, bit commit);
    longint la = longint'(a);
    longint lb = (d == 0) ? longint'(BASE_A) : longint'(BASE_B);
    longint sz = (d == 0) ? longint'(DEPTH_A * 4) : longint'(DEPTH_B * 4);
    int     wc = (d == 0) ? WC_A : WC_B;
    bit     bad;
    int     idx;
    logic [31:0] word;
    exp_t   e;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    bad = (la % 4 != 0) || (la < lb) || (la >= lb + sz);
    idx = bad ? 0 : int'((la - lb) / 4);
    word = (d == 0) ? model_a[idx] : model_b[idx];
    e.err = bad;
    e.rdata = (!bad && !w) ? word : 32'd0;
    e.due = cyc + wc + 1;
    if (!bad && w && commit) begin
      for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = wd[8*i +: 8];
      if (d == 0) model_a[idx] = word;
      else        model_b[idx] = word;
    end
    if (push) begin
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  task automatic wait_ready(int d);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) seen = 1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL %s.timeout: got no ready within 40 cycles, expected a response",
               (d == 0) ? "A" : "B");
    end
  endtask

  // Leaves req high so the caller can chain a back-to-back access.
  task automatic access(int d, logic w, logic [31:0] a, logic [31:0] wd, logic [3:0] b);
    issue(d, w, a, wd, b, 1, 1);
    wait_ready(d);
    @(posedge clk); #1;
  endtask

  task automatic gap(int d, int n);
    req[d] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] gen_addr(int d);
    logic [31:0] b  = (d == 0) ? BASE_A : BASE_B;
    int          dp = (d == 0) ? DEPTH_A : DEPTH_B;
    int          r  = int'($urandom_range(0, 9));
    case (r)
      0, 1, 2, 3, 4, 5: return b + 32'(4 * $urandom_range(0, dp - 1));
      6:                return b + 32'(4 * $urandom_range(0, dp - 1)) + 32'($urandom_range(1, 3));
      7:                return b + 32'(dp * 4) + 32'(4 * $urandom_range(0, 3));
      8:                return b - 32'd4;
      default:          return $urandom;
    endcase
  endfunction

  task automatic random_phase(int d, int n);
    for (int i = 0; i < n; i++) begin
      access(d, 1'($urandom_range(0, 1)), gen_addr(d), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) gap(d, int'($urandom_range(1, 2)));
    end
    gap(d, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0; prev_rdy[d] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Fill both memories so every later load has a known expectation.
    for (int i = 0; i < DEPTH_A; i++) access(0, 1'b1, BASE_A + 32'(4 * i), $urandom, 4'hF);
    gap(0, 1);
    for (int i = 0; i < DEPTH_B; i++) access(1, 1'b1, BASE_B + 32'(4 * i), $urandom, 4'hF);
    gap(1, 1);

    // Basic store then load, byte enables, misaligned and range boundaries.
    access(0, 1'b1, 32'h50, 32'd7, 4'hF);
    access(0, 1'b0, 32'h50, 32'd0, 4'h0);
    access(0, 1'b1, 32'h54, 32'hAABB_CCDD, 4'hF);
    access(0, 1'b1, 32'h54, 32'h1122_3344, 4'b0101);
    access(0, 1'b0, 32'h54, 32'd0, 4'h0);
    access(0, 1'b1, 32'h54, 32'hFFFF_FFFF, 4'b0000);
    access(0, 1'b0, 32'h54, 32'd0, 4'h0);
    access(0, 1'b0, 32'h52, 32'd0, 4'h0);
    access(0, 1'b1, 32'h52, 32'hDEAD_BEEF, 4'hF);
    access(0, 1'b0, 32'h50, 32'd0, 4'h0);
    access(0, 1'b0, 32'h100, 32'd0, 4'h0);
    access(0, 1'b0, 32'hFC, 32'd0, 4'h0);
    gap(0, 2);

    // Reset one cycle after capture: no response, no write.
    issue(0, 1'b1, 32'h58, 32'd5, 4'hF, 0, 0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    gap(0, 5);
    access(0, 1'b0, 32'h58, 32'd0, 4'h0);
    gap(0, 1);

    // Reset on the edge leaving RESP: the pulse is seen but the store is dropped.
    issue(0, 1'b1, 32'h5C, 32'h1234_5678, 4'hF, 1, 0);
    wait_ready(0);
    reset = 1'b1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    gap(0, 2);
    access(0, 1'b0, 32'h5C, 32'd0, 4'h0);
    gap(0, 1);

    random_phase(0, 150);

    // Zero wait states with req held high: responses must alternate 1,0,1,0.
    for (int i = 0; i < 20; i++)
      access(1, 1'b0, BASE_B + 32'(4 * $urandom_range(0, DEPTH_B - 1)), 32'd0, 4'h0);
    access(1, 1'b0, BASE_B + 32'(DEPTH_B * 4), 32'd0, 4'h0);
    access(1, 1'b0, BASE_B - 32'd4, 32'd0, 4'h0);
    gap(1, 1);
    random_phase(1, 100);

    gap(0, 5);
    chk("A.queue_drained", 32'(qa.size()), 32'd0);
    chk("B.queue_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Word-addressed data-memory responder: the target end of the processor's data-memory port.
- It is the multi-cycle, handshaked replacement for the zero-latency dmem.
- Accepts one load/store request at a time, inserts a programmable number of wait states, then returns read data or commits the write with a single-cycle ready pulse.
- Flags misaligned or out-of-range accesses instead of silently aliasing.

Parameters:
- DEPTH, 64, number of 32-bit words in storage; power of two, ≥4.
- WAIT_CYCLES, 2, wait states between capture and response; 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  initiator request; held high with stable fields until ready
- we  input  1  1 = store, 0 = load
- addr  input  32  byte address
- wdata  input  32  store data
- be  input  4  byte enables for stores; be[0] = wdata[7:0]
- ready  output  1  one-cycle response strobe
- rdata  output  32  load data, valid only while ready=1
- err  output  1  access error, valid only while ready=1

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values: state=IDLE, ready=0, err=0, rdata=0, wait counter=0.
- Storage array is not cleared by reset.
- States:
  - IDLE
    - If req=1, capture we/addr/wdata/be and evaluate the error condition.
    - If WAIT_CYCLES=0, go to RESP; otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
  - WAIT
    - Decrement the counter each cycle.
    - When counter=0 and the cycle completes, go to RESP.
    - Inputs are ignored in WAIT; the captured copy is used.
  - RESP
    - Drive ready=1 for exactly one cycle, then return to IDLE.
    - req sampled in RESP is not accepted; a back-to-back request is captured in the following IDLE cycle.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the capturing edge. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Error condition: captured addr[1:0]≠0, or (addr-BASE_ADDR) ≥ DEPTH*4.
  - On error: err=1, rdata=0, no write.
- Word index: (addr-BASE_ADDR)[log2(DEPTH)+1:2].
- Loads: rdata = mem[index] registered into RESP. Outside RESP, rdata=0.
- Stores: write commits on the edge that leaves RESP, only bytes with be[i]=1.
  - be=4'b0000 is a legal no-op store: ready=1, err=0.
  - rdata=0 for stores.
- Address wrap: none. An address past the top is an error, never modulo.
- Reset asserted in WAIT or RESP: return to IDLE next edge with ready=0 and no write committed. The initiator must reissue.
- req dropped before ready is a protocol violation; the responder still completes the captured access.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2); byte-enable width (4); word-offset width (2).
- One natural sub-module, byte_merge: combinational merge of wdata into the old word under be, used on the write path.
- Counter and FSM stay in the top.

Test Plan:
1. WAIT_CYCLES=2. Store addr=0x50, wdata=7, be=4'hF at cycle 0. ready=1 at cycle 3, err=0. Then load 0x50 → ready at cycle 3 of that access with rdata=7.
2. Byte enables: word 0x54 holds 0xAABBCCDD; store wdata=0x11223344 with be=4'b0101 → subsequent load of 0x54 returns 0xAA22CC44.
3. Misaligned load at addr=0x52 → ready after 3 cycles with err=1, rdata=0. Misaligned store at 0x52 → err=1 and 0x50 unchanged.
4. Out of range (DEPTH=64): load at 0x100 → err=1. Load at 0xFC → err=0, returns the stored word.
5. Reset during WAIT: issue store to 0x58 with wdata=5, assert reset one cycle after capture. ready stays 0, state returns to IDLE, and a later load of 0x58 returns the old value.
6. WAIT_CYCLES=0, back-to-back loads with req held high: ready pulses every second cycle (1,0,1,0) and never two consecutive cycles.
